// File: rtl/safe_lock_ctrl_pkg.sv
// Shared types for the safe lock controller: FSM states and keypad key codes.
// SETPW exists only when PWD_CHANGE_EN is defined.
package safe_lock_ctrl_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
`ifdef PWD_CHANGE_EN
    , SETPW = 2'd3
`endif
  } fsm_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_LOCK  = 4'hC;
  localparam logic [3:0] KEY_SET   = 4'hD;

  function automatic logic is_digit(logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/safe_lock_ctrl_if.sv
// Keypad in / lock status out bundle between the keypad scanner and the lock.
interface safe_lock_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       state;
  logic       alarm;
  logic       err;
  logic [2:0] digit_cnt;

  modport master (output key_valid, key_code, input state, alarm, err, digit_cnt);
  modport slave  (input key_valid, key_code, output state, alarm, err, digit_cnt);
endinterface

// File: rtl/lockout_timer.sv
// Lockout interval counter: start loads it, busy holds for CYCLES cycles,
// done flags the final cycle so the owner can leave lockout on that edge.
module lockout_timer #(
  parameter int unsigned CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);
  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
    end else if (busy) begin
      if (count == W'(CYCLES - 1)) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

  assign done = busy && (count == W'(CYCLES - 1));

endmodule

// File: rtl/safe_lock_ctrl.sv
// Keypad lock FSM: digit entry, password compare, wrong-try lockout with alarm.
// Define PWD_CHANGE_EN to build in the SETPW (password change) state.
module safe_lock_ctrl
  import safe_lock_ctrl_pkg::*;
#(
  parameter int unsigned         DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_PWD    = 16'h1234,
  parameter int unsigned         MAX_TRIES      = 3,
  parameter int unsigned         LOCKOUT_CYCLES = 50_000_000
) (
  input logic            clk,
  input logic            rst,
  safe_lock_ctrl_if.slave bus
);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);

  fsm_t          fsm;
  logic [BW-1:0] entry;
  logic [BW-1:0] pwd;
  logic [2:0]    cnt;
  logic [TW-1:0] tries;
  logic          dig, ent, clr, lck;
  logic          full, match, trip;
  logic          busy, done;

  assign dig = bus.key_valid && is_digit(bus.key_code);
  assign ent = bus.key_valid && (bus.key_code == KEY_ENTER);
  assign clr = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign lck = bus.key_valid && (bus.key_code == KEY_LOCK);

`ifdef PWD_CHANGE_EN
  logic set;
  assign set = bus.key_valid && (bus.key_code == KEY_SET);
`else
  assign pwd = DEFAULT_PWD;
`endif

  assign full  = (cnt == 3'(DIGITS));
  assign match = full && (entry == pwd);
  // Wrong enter that uses up the last allowed try starts the lockout timer on the same edge
  assign trip  = (fsm == LOCKED) && ent && !match && (tries >= TW'(MAX_TRIES - 1));

  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (trip),
    .busy  (busy),
    .done  (done)
  );

  assign bus.digit_cnt = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= LOCKED;
      entry     <= '0;
      cnt       <= '0;
      tries     <= '0;
      bus.state <= 1'b0;
      bus.alarm <= 1'b0;
      bus.err   <= 1'b0;
`ifdef PWD_CHANGE_EN
      pwd       <= DEFAULT_PWD;
`endif
    end else begin
      bus.err <= 1'b0;
      case (fsm)
        LOCKED: begin
          if (dig) begin
            if (!full) begin
              entry <= {entry[BW-5:0], bus.key_code};
              cnt   <= cnt + 3'd1;
            end
          end else if (clr) begin
            entry <= '0;
            cnt   <= '0;
          end else if (ent) begin
            entry <= '0;
            cnt   <= '0;
            if (match) begin
              fsm       <= OPEN;
              bus.state <= 1'b1;
              tries     <= '0;
            end else begin
              bus.err <= 1'b1;
              if (trip) begin
                fsm       <= LOCKOUT;
                bus.alarm <= 1'b1;
                tries     <= TW'(MAX_TRIES);
              end else begin
                tries <= tries + TW'(1);
              end
            end
          end
        end
        OPEN: begin
          if (lck) begin
            fsm       <= LOCKED;
            bus.state <= 1'b0;
            entry     <= '0;
            cnt       <= '0;
          end
`ifdef PWD_CHANGE_EN
          else if (set) begin
            fsm   <= SETPW;
            entry <= '0;
            cnt   <= '0;
          end
`endif
        end
        LOCKOUT: begin
          // !busy guards against ever sitting here with an idle timer
          if (done || !busy) begin
            fsm       <= LOCKED;
            bus.alarm <= 1'b0;
            tries     <= '0;
          end
        end
`ifdef PWD_CHANGE_EN
        SETPW: begin
          if (dig) begin
            if (!full) begin
              entry <= {entry[BW-5:0], bus.key_code};
              cnt   <= cnt + 3'd1;
            end
          end else if (ent) begin
            entry <= '0;
            cnt   <= '0;
            if (full) begin
              pwd <= entry;
              fsm <= OPEN;
            end else begin
              bus.err <= 1'b1;
            end
          end else if (clr) begin
            fsm   <= OPEN;
            entry <= '0;
            cnt   <= '0;
          end else if (lck) begin
            fsm       <= LOCKED;
            bus.state <= 1'b0;
            entry     <= '0;
            cnt       <= '0;
          end
        end
`endif
        default: begin
          fsm       <= LOCKED;
          bus.state <= 1'b0;
          bus.alarm <= 1'b0;
          entry     <= '0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule
